// File: rtl/piezo_arb_pkg.sv
// Shared constants, owner codes, state type and jingle note table for the piezo arbiter.
// Optional build macro PIEZO_ARB_GAP_EN enables GAP_MS silences between jingle notes.
package piezo_arb_pkg;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_MISS  = 2'd1;
    localparam logic [1:0] OWN_START = 2'd2;
    localparam logic [1:0] OWN_END   = 2'd3;

    localparam int JINGLE_LEN = 4;
    localparam int CNT_W      = 16;

    // Durations are counted in 1 ms ticks.
    localparam logic [CNT_W-1:0] NOTE_MS    = 16'd150;
    localparam logic [CNT_W-1:0] MISS_MS    = 16'd80;
    localparam logic [CNT_W-1:0] GAP_MS     = 16'd20;
    localparam logic [31:0]      MISS_LIMIT = 32'd250000;

    // Start jingle C5, E5, G5, C6; entry 0 sits in the low word.
    localparam logic [JINGLE_LEN-1:0][31:0] START_NOTES =
        {32'd23900, 32'd31888, 32'd37936, 32'd47801};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT,
        ST_MISS,
        ST_START_J,
        ST_END_J
    } state_t;

    // The end jingle walks the same table backwards.
    function automatic logic [31:0] note_limit(input logic [1:0] idx, input logic rev);
        logic [1:0] sel;
        sel = rev ? (2'd3 - idx) : idx;
        return START_NOTES[sel];
    endfunction

endpackage

// File: rtl/piezo_arbiter_if.sv
// Request and buzzer-control bundle between game logic, the arbiter and piezo_ctrl.
interface piezo_arbiter_if;
    logic        i_tick;
    logic        i_hit_en;
    logic [31:0] i_hit_limit;
    logic        i_miss_pulse;
    logic        i_start_pulse;
    logic        i_end_pulse;
    logic        o_play_en;
    logic [31:0] o_cnt_limit;
    logic [1:0]  o_owner;
    logic        o_busy;

    modport master (
        output i_tick, i_hit_en, i_hit_limit, i_miss_pulse, i_start_pulse, i_end_pulse,
        input  o_play_en, o_cnt_limit, o_owner, o_busy
    );

    modport slave (
        input  i_tick, i_hit_en, i_hit_limit, i_miss_pulse, i_start_pulse, i_end_pulse,
        output o_play_en, o_cnt_limit, o_owner, o_busy
    );
endinterface

// File: rtl/piezo_jingle_seq.sv
// Jingle note sequencer: note index, per-note tick counter, optional gap phase and done strobe.
// With PIEZO_ARB_GAP_EN defined, a GAP_MS silence follows every note except the last.
module piezo_jingle_seq
    import piezo_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_dir,
    input  logic        i_active,
    input  logic        i_tick,
    output logic [31:0] o_limit_next,
    output logic        o_gap_next,
    output logic        o_done
);

    logic [1:0]       r_idx, w_idx_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_gap, w_gap_next;
    logic             r_dir, w_dir_next;

    // A load wins over a tick in the same cycle, so that tick is never counted.
    always_comb begin
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        w_gap_next = r_gap;
        w_dir_next = r_dir;
        o_done     = 1'b0;
        if (i_load) begin
            w_idx_next = 2'd0;
            w_cnt_next = NOTE_MS;
            w_gap_next = 1'b0;
            w_dir_next = i_dir;
        end else if (i_active && i_tick) begin
            if (r_cnt == CNT_W'(1)) begin
                if (!r_gap && (r_idx == 2'(JINGLE_LEN - 1))) begin
                    o_done = 1'b1;
`ifdef PIEZO_ARB_GAP_EN
                end else if (!r_gap) begin
                    w_gap_next = 1'b1;
                    w_cnt_next = GAP_MS;
`endif
                end else begin
                    w_gap_next = 1'b0;
                    w_idx_next = r_idx + 2'd1;
                    w_cnt_next = NOTE_MS;
                end
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_limit_next = note_limit(w_idx_next, w_dir_next);
    assign o_gap_next   = w_gap_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_cnt <= '0;
            r_gap <= 1'b0;
            r_dir <= 1'b0;
        end else begin
            r_idx <= w_idx_next;
            r_cnt <= w_cnt_next;
            r_gap <= w_gap_next;
            r_dir <= w_dir_next;
        end
    end

endmodule

// File: rtl/piezo_arbiter.sv
// Fixed-priority buzzer arbiter (END > START > MISS > HIT) with preemption and registered outputs.
// Build macro PIEZO_ARB_GAP_EN (handled in piezo_jingle_seq) inserts silences between jingle notes.
module piezo_arbiter
    import piezo_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    piezo_arbiter_if.slave bus
);

    state_t           r_state, w_state_next, w_exit_state;
    logic [CNT_W-1:0] r_miss_cnt, w_miss_cnt_next;
    logic             r_play_en, w_play_en_next;
    logic [31:0]      r_cnt_limit, w_cnt_limit_next;
    logic [1:0]       r_owner, w_owner_next;
    logic             r_busy, w_busy_next;

    logic        w_seq_load, w_seq_dir, w_seq_active, w_seq_done, w_seq_gap_next;
    logic [31:0] w_seq_limit_next;

    assign w_seq_active = (r_state == ST_START_J) || (r_state == ST_END_J);
    assign w_seq_load   = bus.i_end_pulse || (bus.i_start_pulse && (r_state != ST_END_J));
    assign w_seq_dir    = bus.i_end_pulse;
    assign w_exit_state = bus.i_hit_en ? ST_HIT : ST_IDLE;

    piezo_jingle_seq u_seq (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_seq_load),
        .i_dir        (w_seq_dir),
        .i_active     (w_seq_active),
        .i_tick       (bus.i_tick),
        .o_limit_next (w_seq_limit_next),
        .o_gap_next   (w_seq_gap_next),
        .o_done       (w_seq_done)
    );

    always_comb begin
        w_state_next     = r_state;
        w_miss_cnt_next  = r_miss_cnt;
        w_play_en_next   = 1'b0;
        w_cnt_limit_next = r_cnt_limit;
        w_owner_next     = OWN_NONE;
        w_busy_next      = 1'b0;

        // Pulses outrank everything below them; lower ones are simply dropped.
        if (bus.i_end_pulse) begin
            w_state_next = ST_END_J;
        end else if (bus.i_start_pulse && (r_state != ST_END_J)) begin
            w_state_next = ST_START_J;
        end else if (bus.i_miss_pulse && !w_seq_active) begin
            w_state_next    = ST_MISS;
            w_miss_cnt_next = MISS_MS;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.i_hit_en) w_state_next = ST_HIT;
                ST_HIT:  if (!bus.i_hit_en) w_state_next = ST_IDLE;
                ST_MISS: begin
                    if (bus.i_tick) begin
                        if (r_miss_cnt == CNT_W'(1)) w_state_next = w_exit_state;
                        else w_miss_cnt_next = r_miss_cnt - CNT_W'(1);
                    end
                end
                ST_START_J, ST_END_J: if (w_seq_done) w_state_next = w_exit_state;
                default: w_state_next = ST_IDLE;
            endcase
        end

        case (w_state_next)
            ST_HIT: begin
                w_play_en_next   = 1'b1;
                w_cnt_limit_next = bus.i_hit_limit;
            end
            ST_MISS: begin
                w_play_en_next   = 1'b1;
                w_cnt_limit_next = MISS_LIMIT;
                w_owner_next     = OWN_MISS;
                w_busy_next      = 1'b1;
            end
            ST_START_J, ST_END_J: begin
                w_play_en_next = !w_seq_gap_next;
                if (!w_seq_gap_next) w_cnt_limit_next = w_seq_limit_next;
                w_owner_next = (w_state_next == ST_START_J) ? OWN_START : OWN_END;
                w_busy_next  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_miss_cnt  <= '0;
            r_play_en   <= 1'b0;
            r_cnt_limit <= '0;
            r_owner     <= OWN_NONE;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_miss_cnt  <= w_miss_cnt_next;
            r_play_en   <= w_play_en_next;
            r_cnt_limit <= w_cnt_limit_next;
            r_owner     <= w_owner_next;
            r_busy      <= w_busy_next;
        end
    end

    assign bus.o_play_en   = r_play_en;
    assign bus.o_cnt_limit = r_cnt_limit;
    assign bus.o_owner     = r_owner;
    assign bus.o_busy      = r_busy;

endmodule

// File: doc/piezo_arbiter.md
Name: piezo_arbiter

Overview:
- Sole owner of the piezo_ctrl inputs (i_play_en, i_cnt_limit). Shares the single buzzer between four requesters:
  - the continuous hit tone from judgement_ctrl;
  - a fixed-length miss beep;
  - a start jingle;
  - an end jingle.
- Applies fixed priority with preemption and sequences the multi-note jingles in 1 ms ticks.
- Sits between judgement_ctrl / game flow logic and piezo_ctrl inside sys_base.

Parameters:
- NOTE_MS, 150, duration of each jingle note in ticks (1 ms each)
- MISS_MS, 80, duration of the miss beep in ticks
- GAP_MS, 20, silence between jingle notes in ticks (used only with the optional feature)
- MISS_LIMIT, 250000, cnt_limit for the miss beep (100 Hz at 50 MHz)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- i_tick  in  1  1 ms single-cycle strobe from clk_div
- i_hit_en  in  1  level; judgement hit tone requested
- i_hit_limit  in  32  cnt_limit for the hit tone
- i_miss_pulse  in  1  single-cycle miss beep request
- i_start_pulse  in  1  single-cycle start jingle request
- i_end_pulse  in  1  single-cycle end jingle request (game over)
- o_play_en  out  1  to piezo_ctrl i_play_en
- o_cnt_limit  out  32  to piezo_ctrl i_cnt_limit
- o_owner  out  2  current owner: 0 = none/hit, 1 = miss, 2 = start, 3 = end
- o_busy  out  1  high while a timed sound (miss or jingle) is active

Behaviour:
- Reset: state IDLE; o_play_en = 0, o_cnt_limit = 0, o_owner = 0, o_busy = 0; duration counter = 0, note index = 0.
- All outputs are registered. A request is sampled at clock edge N; outputs reflect it after edge N+1 (1-cycle latency).
- Priority, highest first: END > START > MISS > HIT.
  - A higher-priority request preempts any lower one immediately; the aborted sound is discarded, not resumed.
  - A lower-priority pulse arriving while a higher sound is active is dropped.
  - Same-priority re-trigger restarts that sound: counter reload, note index reset to 0.
  - Simultaneous pulses in one cycle: the highest wins; the others are dropped.
- States:
  - IDLE: o_play_en = 0. Go to HIT if i_hit_en; to MISS, START_J or END_J on the matching pulse.
  - HIT: o_play_en = 1, o_cnt_limit tracks i_hit_limit every cycle. Return to IDLE when i_hit_en falls.
  - MISS: load counter = MISS_MS, o_cnt_limit = MISS_LIMIT, o_owner = 1, o_busy = 1.
  - START_J / END_J: note index 0..3 from the package table. Counter = NOTE_MS per note. o_owner = 2 or 3, o_busy = 1.
- Duration counting:
  - The counter decrements only on i_tick.
  - An i_tick in the same cycle as the load is ignored.
  - Expiry occurs on the i_tick that finds counter == 1.
- Expiry handling:
  - MISS: exit.
  - Jingle: advance the note index. After note 3, exit.
  - Exit goes to HIT if i_hit_en is high at that cycle, else to IDLE. o_busy clears on exit.
- Tones:
  - Start jingle: C5, E5, G5, C6 = 47801, 37936, 31888, 23900.
  - End jingle: the same table in reverse order.
- o_cnt_limit holds its last value when o_play_en = 0.
- Reset asserted mid-sound returns to the reset state immediately (asynchronous).

Optional Feature:
- PIEZO_ARB_GAP_EN defined:
  - Between consecutive jingle notes, insert GAP_MS ticks with o_play_en = 0 and o_cnt_limit held. o_owner and o_busy stay asserted.
  - No gap follows note 3.
  - Preemption rules also apply during a gap.
- Not defined: notes are back-to-back, and the next note's o_cnt_limit appears on the cycle after expiry.

Decomposition:
- Package piezo_arb_pkg holds:
  - owner encoding constants (OWN_NONE, OWN_MISS, OWN_START, OWN_END);
  - the state enum;
  - the 4-entry start note table;
  - the jingle length constant (4).
- One sub-module is natural: piezo_jingle_seq (note index, tick counter, optional gap phase, done pulse), instantiated once with direction select.

Test Plan:
- Reset, then i_hit_en = 1 with i_hit_limit = 47801: o_play_en = 1 and o_cnt_limit = 47801 one cycle later. Drop i_hit_en: o_play_en = 0 next cycle.
- i_miss_pulse with i_hit_en held: o_owner = 1, o_cnt_limit = 250000 for exactly 80 ticks, then return to the hit tone with o_owner = 0 and o_busy = 0.
- i_start_pulse: o_cnt_limit sequence 47801, 37936, 31888, 23900, each held 150 ticks. o_busy is high for 600 ticks (660 with PIEZO_ARB_GAP_EN).
- i_end_pulse at tick 200 of the start jingle: immediate switch to 23900 with o_owner = 3. The end sequence completes in reverse; the start jingle never resumes.
- i_miss_pulse during the end jingle, and i_start_pulse plus i_end_pulse in the same cycle: the miss is dropped and END wins.
- rst asserted mid-jingle: all outputs 0 without waiting for a clock edge; after release, o_owner = 0.
